// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
//
// Purpose:
//   Instruction-decode stage of a five-stage MIPS-style pipeline. It produces
//   every D-suffixed signal captured by the ID/EX register. It contains:
//   - the 32-entry register file, written from WB and readable in the same
//     cycle through a write-before-read bypass;
//   - the main decoder and the ALU decoder;
//   - the sign extender and the branch-target adder;
//   - early beq resolution, with forwarding from MEM;
//   - load-use and branch hazard detection.
//
// Port summary:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   InstrD, PCPlus4D      instruction and PC+4 from the IF/ID register
//   RegWriteW, WriteRegW,
//   ResultW               register-file write port driven by WB
//   RegWriteE, MemtoRegE,
//   WriteRegE, RtE        EX-stage instruction info for hazard detection
//   RegWriteM, MemtoRegM,
//   WriteRegM, ALUOutM    MEM-stage info for branch forwarding and stalls
//   RegWriteD .. RegDstD,
//   ALUControlD           decoded control
//                         (ALUControlD: 00 ADD, 01 SUB, 10 AND, 11 OR)
//   RD1_D, RD2_D          register read data for rs and rt
//   RsD, RtD, RdD         register fields of the instruction
//   ext_imm32D            sign-extended 16-bit immediate
//   PCSrcD, PCBranchD     branch taken flag and branch target
//   StallF, StallD,
//   FlushE                hazard controls toward IF/ID and ID/EX
// ---------------------------------------------------------------------------
module id_decode_stage #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      WriteRegW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            RegWriteE,
   input  logic            MemtoRegE,
   input  logic [4:0]      WriteRegE,
   input  logic [4:0]      RtE,
   input  logic            RegWriteM,
   input  logic            MemtoRegM,
   input  logic [4:0]      WriteRegM,
   input  logic [XLEN-1:0] ALUOutM,
   output logic            RegWriteD,
   output logic            MemtoRegD,
   output logic            MemWriteD,
   output logic            ALUsrcD,
   output logic            RegDstD,
   output logic [1:0]      ALUControlD,
   output logic [XLEN-1:0] RD1_D,
   output logic [XLEN-1:0] RD2_D,
   output logic [4:0]      RsD,
   output logic [4:0]      RtD,
   output logic [4:0]      RdD,
   output logic [XLEN-1:0] ext_imm32D,
   output logic            PCSrcD,
   output logic [XLEN-1:0] PCBranchD,
   output logic            StallF,
   output logic            StallD,
   output logic            FlushE
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;

   // ALU operation class handed from the main decoder to the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   logic [XLEN-1:0] regs_q [NREG];

   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic [1:0]      aluOp;
   logic            branchD;
   logic [XLEN-1:0] cmpA;
   logic [XLEN-1:0] cmpB;
   logic            loadUseStall;
   logic            branchStall;
   logic            stall;

   assign opcode = InstrD[31:26];
   assign funct  = InstrD[5:0];
   assign RsD    = InstrD[25:21];
   assign RtD    = InstrD[20:16];
   assign RdD    = InstrD[15:11];

   // The register file is cleared asynchronously. Entry 0 is never written,
   // so it keeps its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (RegWriteW && (WriteRegW != 5'd0)) begin
         regs_q[WriteRegW] <= ResultW;
      end
   end

   // Combinational read ports. Register 0 reads as zero, and both ports read
   // zero while reset is held. A WB write to the same register in the same
   // cycle is bypassed, so ID sees the value that is about to be stored.
   always_comb begin
      RD1_D = '0;
      RD2_D = '0;
      if (rst_n) begin
         if (RsD != 5'd0) begin
            RD1_D = (RegWriteW && (WriteRegW == RsD)) ? ResultW : regs_q[RsD];
         end
         if (RtD != 5'd0) begin
            RD2_D = (RegWriteW && (WriteRegW == RtD)) ? ResultW : regs_q[RtD];
         end
      end
   end

   // Main decoder. Unknown opcodes fall through to an all-zero NOP.
   always_comb begin
      RegWriteD = 1'b0;
      RegDstD   = 1'b0;
      ALUsrcD   = 1'b0;
      MemWriteD = 1'b0;
      MemtoRegD = 1'b0;
      branchD   = 1'b0;
      aluOp     = ALUOP_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            RegWriteD = 1'b1;
            RegDstD   = 1'b1;
            aluOp     = ALUOP_FUNCT;
         end
         OP_LW: begin
            RegWriteD = 1'b1;
            ALUsrcD   = 1'b1;
            MemtoRegD = 1'b1;
         end
         OP_SW: begin
            ALUsrcD   = 1'b1;
            MemWriteD = 1'b1;
         end
         OP_ADDI: begin
            RegWriteD = 1'b1;
            ALUsrcD   = 1'b1;
         end
         OP_BEQ: begin
            branchD = 1'b1;
            aluOp   = ALUOP_SUB;
         end
         default: begin
         end
      endcase
   end

   // ALU decoder. Unrecognised R-type funct codes behave as ADD.
   always_comb begin
      ALUControlD = 2'b00;
      if (aluOp == ALUOP_SUB) begin
         ALUControlD = 2'b01;
      end else if (aluOp == ALUOP_FUNCT) begin
         unique case (funct)
            FN_ADD:  ALUControlD = 2'b00;
            FN_SUB:  ALUControlD = 2'b01;
            FN_AND:  ALUControlD = 2'b10;
            FN_OR:   ALUControlD = 2'b11;
            default: ALUControlD = 2'b00;
         endcase
      end
   end

   assign ext_imm32D = {{(XLEN-16){InstrD[15]}}, InstrD[15:0]};
   assign PCBranchD  = PCPlus4D + (ext_imm32D << 2);

   // The branch comparator sits in ID, so a result still in MEM must be
   // forwarded around the register file to resolve beq without waiting.
   always_comb begin
      cmpA = RD1_D;
      cmpB = RD2_D;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD)) begin
         cmpA = ALUOutM;
      end
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD)) begin
         cmpB = ALUOutM;
      end
   end

   // Hazard detection. A load in EX cannot forward in time for the consumer
   // in ID. beq needs its operands in ID, so it must also wait for an ALU
   // result still in EX, or for a load result still in MEM.
   always_comb begin
      loadUseStall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
      branchStall  = branchD &&
                     ((RegWriteE && (WriteRegE != 5'd0) &&
                       ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (MemtoRegM && (WriteRegM != 5'd0) &&
                       ((WriteRegM == RsD) || (WriteRegM == RtD))));
      stall        = loadUseStall || branchStall;
   end

   assign StallF = stall;
   assign StallD = stall;
   assign FlushE = stall;

   // A stalled branch must not redirect the PC, because its operands are
   // not yet valid.
   assign PCSrcD = branchD && (cmpA == cmpB) && !stall;

endmodule

// File: tb/tb_id_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_id_decode_stage
//
// Purpose:
//   Self-checking bench for id_decode_stage. It runs directed scenarios and
//   then randomized traffic. All expected values come from a behavioural
//   model kept in this file: an array of architectural registers plus
//   decode, hazard and branch rules written as plain arithmetic.
// ---------------------------------------------------------------------------
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrD, PCPlus4D, ResultW, ALUOutM;
   logic        RegWriteW, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
   logic [4:0]  WriteRegW, WriteRegE, RtE, WriteRegM;
   logic        RegWriteD, MemtoRegD, MemWriteD, ALUsrcD, RegDstD;
   logic [1:0]  ALUControlD;
   logic [31:0] RD1_D, RD2_D, ext_imm32D, PCBranchD;
   logic [4:0]  RsD, RtD, RdD;
   logic        PCSrcD, StallF, StallD, FlushE;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelRegs [32];

   id_decode_stage #(.NREG(32), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
      .RtE(RtE), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
      .ALUsrcD(ALUsrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
      .RD1_D(RD1_D), .RD2_D(RD2_D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .ext_imm32D(ext_imm32D), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE)
   );

   always #5 clk = ~clk;

   // Architectural register model: cleared by reset, updated by WB writes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
      end else if (RegWriteW && WriteRegW != 5'd0) begin
         modelRegs[WriteRegW] = ResultW;
      end
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Value an instruction in ID should see for a register right now.
   function automatic logic [31:0] expRead(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'h0;
      if (RegWriteW && WriteRegW == a) return ResultW;
      return modelRegs[a];
   endfunction

   // {RegWrite, RegDst, ALUsrc, MemWrite, MemtoReg, ALUControl[1:0]}
   function automatic logic [6:0] expCtrl(input logic [31:0] ins);
      case (ins[31:26])
         6'h00: case (ins[5:0])
                   6'h22:   return 7'b11000_01;
                   6'h24:   return 7'b11000_10;
                   6'h25:   return 7'b11000_11;
                   default: return 7'b11000_00;
                endcase
         6'h23:   return 7'b10101_00;
         6'h2B:   return 7'b00110_00;
         6'h08:   return 7'b10100_00;
         6'h04:   return 7'b00000_01;
         default: return 7'b00000_00;
      endcase
   endfunction

   function automatic logic expStall();
      logic [4:0] rs, rt;
      logic lu, br;
      rs = InstrD[25:21];
      rt = InstrD[20:16];
      lu = MemtoRegE && (RtE == rs || RtE == rt);
      br = (InstrD[31:26] == 6'h04) &&
           ((RegWriteE && WriteRegE != 0 && (WriteRegE == rs || WriteRegE == rt)) ||
            (MemtoRegM && WriteRegM != 0 && (WriteRegM == rs || WriteRegM == rt)));
      return lu || br;
   endfunction

   function automatic logic expPcSrc();
      logic [4:0] rs, rt;
      logic [31:0] a, b;
      rs = InstrD[25:21];
      rt = InstrD[20:16];
      a = (RegWriteM && WriteRegM != 0 && WriteRegM == rs) ? ALUOutM : expRead(rs);
      b = (RegWriteM && WriteRegM != 0 && WriteRegM == rt) ? ALUOutM : expRead(rt);
      return (InstrD[31:26] == 6'h04) && (a == b) && !expStall();
   endfunction

   function automatic logic [31:0] expImm(input logic [31:0] ins);
      return 32'(int'($signed(ins[15:0])));
   endfunction

   function automatic logic [31:0] expTarget();
      return PCPlus4D + 32'(int'($signed(InstrD[15:0])) * 4);
   endfunction

   function automatic logic [31:0] randInstr();
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      logic [31:0] ins;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h07};
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) ins[31:26] = 6'($urandom);
      ins[25:21] = 5'($urandom_range(0, 4));
      ins[20:16] = 5'($urandom_range(0, 4));
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 4)];
      return ins;
   endfunction

   // Puts every pipeline-side input into a quiet state.
   task automatic applyStimulus();
      RegWriteW = 0; WriteRegW = 0; ResultW = 0;
      RegWriteE = 0; MemtoRegE = 0; WriteRegE = 0; RtE = 0;
      RegWriteM = 0; MemtoRegM = 0; WriteRegM = 0; ALUOutM = 0;
      PCPlus4D = 32'h0000_0100;
   endtask

   task automatic test_reset();
      rst_n = 0;
      applyStimulus();
      InstrD = rtype(5'd5, 5'd6, 5'd7, 6'h20);
      #1;
      checks++;
      if ({RD1_D, RD2_D} !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_read: got %h/%h expected 0/0", RD1_D, RD2_D);
      end
      checks++;
      if ({RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD} !== 7'b11000_00) begin
         errors++; $display("[TB] FAIL reset_decode: got %b expected %b",
            {RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD}, 7'b11000_00);
      end
      @(negedge clk); rst_n = 1;
      RegWriteW = 1; WriteRegW = 5'd5; ResultW = 32'h1234;
      @(negedge clk); RegWriteW = 0;
      #1;
      checks++;
      if (RD1_D !== 32'h1234) begin
         errors++; $display("[TB] FAIL write_reg5: got %h expected %h", RD1_D, 32'h1234);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if (RD1_D !== 32'h0) begin
         errors++; $display("[TB] FAIL async_reset_read: got %h expected 0", RD1_D);
      end
      @(negedge clk); rst_n = 1;
      #1;
      checks++;
      if (RD1_D !== 32'h0) begin
         errors++; $display("[TB] FAIL post_reset_read: got %h expected 0", RD1_D);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      applyStimulus();
      RegWriteW = 1; WriteRegW = 5'd8; ResultW = 32'hDEAD_BEEF;
      InstrD = rtype(5'd8, 5'd0, 5'd8, 6'h20);
      #1;
      checks++;
      if (RD1_D !== 32'hDEAD_BEEF) begin
         errors++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", RD1_D);
      end
      @(negedge clk); RegWriteW = 0; ResultW = 32'h5555_5555;
      #1;
      checks++;
      if (RD1_D !== 32'hDEAD_BEEF) begin
         errors++; $display("[TB] FAIL bypass_stored: got %h expected deadbeef", RD1_D);
      end
      @(negedge clk);
      RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'h0000_FFFF;
      InstrD = rtype(5'd0, 5'd0, 5'd1, 6'h20);
      #1;
      checks++;
      if (RD1_D !== 32'h0) begin
         errors++; $display("[TB] FAIL reg0_write_cycle: got %h expected 0", RD1_D);
      end
      @(negedge clk); RegWriteW = 0;
      #1;
      checks++;
      if ({RD1_D, RD2_D} !== 64'h0) begin
         errors++; $display("[TB] FAIL reg0_after_write: got %h/%h expected 0/0", RD1_D, RD2_D);
      end
   endtask

   task automatic test_decode();
      @(negedge clk);
      applyStimulus();
      InstrD = itype(6'h23, 5'd3, 5'd2, 16'hFFFC);
      #1;
      checks++;
      if ({RegWriteD, MemtoRegD, ALUsrcD, RegDstD, MemWriteD} !== 5'b11100) begin
         errors++; $display("[TB] FAIL decode_lw: got %b expected 11100",
            {RegWriteD, MemtoRegD, ALUsrcD, RegDstD, MemWriteD});
      end
      checks++;
      if (ext_imm32D !== 32'hFFFF_FFFC) begin
         errors++; $display("[TB] FAIL decode_lw_imm: got %h expected fffffffc", ext_imm32D);
      end
      InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h22);
      #1;
      checks++;
      if ({ALUControlD, RegDstD, RdD} !== {2'b01, 1'b1, 5'd3}) begin
         errors++; $display("[TB] FAIL decode_sub: got %b/%b/%0d expected 01/1/3",
            ALUControlD, RegDstD, RdD);
      end
      InstrD = {6'h3F, 26'h3FF_FFFF};
      #1;
      checks++;
      if ({RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD} !== 7'b0) begin
         errors++; $display("[TB] FAIL decode_unknown: got %b expected 0",
            {RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD});
      end
      for (int i = 0; i < 40; i++) begin
         InstrD = randInstr();
         InstrD[25:11] = 15'($urandom);
         #1;
         checks++;
         if ({RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD} !== expCtrl(InstrD) ||
             {RsD, RtD, RdD} !== InstrD[25:11] || ext_imm32D !== expImm(InstrD)) begin
            errors++; $display("[TB] FAIL decode_random: instr %h got ctrl %b imm %h expected ctrl %b imm %h",
               InstrD, {RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD},
               ext_imm32D, expCtrl(InstrD), expImm(InstrD));
         end
      end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      applyStimulus();
      MemtoRegE = 1; RtE = 5'd4; WriteRegE = 5'd4; RegWriteE = 1;
      InstrD = rtype(5'd4, 5'd7, 5'd9, 6'h20);
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b111) begin
         errors++; $display("[TB] FAIL load_use_rs: got %b expected 111", {StallF, StallD, FlushE});
      end
      @(negedge clk);
      MemtoRegE = 0; RegWriteE = 0; RtE = 5'd0; WriteRegE = 5'd0;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b000) begin
         errors++; $display("[TB] FAIL load_use_release: got %b expected 000", {StallF, StallD, FlushE});
      end
      MemtoRegE = 1; RtE = 5'd7;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b111) begin
         errors++; $display("[TB] FAIL load_use_rt: got %b expected 111", {StallF, StallD, FlushE});
      end
      for (int i = 0; i < 30; i++) begin
         InstrD = randInstr();
         MemtoRegE = 1'($urandom); RtE = 5'($urandom_range(0, 4));
         RegWriteE = 1'($urandom); WriteRegE = 5'($urandom_range(0, 4));
         MemtoRegM = 1'($urandom); WriteRegM = 5'($urandom_range(0, 4));
         #1;
         checks++;
         if ({StallF, StallD, FlushE} !== {3{expStall()}}) begin
            errors++; $display("[TB] FAIL stall_random: instr %h got %b expected %b",
               InstrD, {StallF, StallD, FlushE}, {3{expStall()}});
         end
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      applyStimulus();
      RegWriteW = 1; WriteRegW = 5'd9; ResultW = 32'd7;
      InstrD = rtype(5'd0, 5'd0, 5'd0, 6'h20);
      @(negedge clk);
      RegWriteW = 0;
      InstrD = itype(6'h04, 5'd9, 5'd0, 16'h0010);
      RegWriteM = 1; WriteRegM = 5'd9; ALUOutM = 32'd0;
      #1;
      checks++;
      if ({PCSrcD, StallD, RD1_D} !== {1'b1, 1'b0, 32'd7}) begin
         errors++; $display("[TB] FAIL beq_mem_forward: got pcsrc %b stall %b rd1 %0d expected 1 0 7",
            PCSrcD, StallD, RD1_D);
      end
      checks++;
      if (PCBranchD !== 32'h0000_0140) begin
         errors++; $display("[TB] FAIL beq_target: got %h expected 00000140", PCBranchD);
      end
      MemtoRegM = 1;
      #1;
      checks++;
      if ({PCSrcD, StallF, StallD, FlushE} !== 4'b0111) begin
         errors++; $display("[TB] FAIL beq_mem_load_stall: got %b expected 0111",
            {PCSrcD, StallF, StallD, FlushE});
      end
      MemtoRegM = 0; RegWriteM = 0;
      #1;
      checks++;
      if ({PCSrcD, StallD} !== 2'b00) begin
         errors++; $display("[TB] FAIL beq_not_taken: got %b expected 00", {PCSrcD, StallD});
      end
      RegWriteE = 1; WriteRegE = 5'd9;
      #1;
      checks++;
      if ({PCSrcD, StallD} !== 2'b01) begin
         errors++; $display("[TB] FAIL beq_ex_stall: got %b expected 01", {PCSrcD, StallD});
      end
      InstrD = rtype(5'd9, 5'd0, 5'd1, 6'h20);
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++; $display("[TB] FAIL nonbranch_no_stall: got %b expected 0", StallD);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      applyStimulus();
      PCPlus4D = 32'hFFFF_FFFC;
      InstrD = itype(6'h04, 5'd1, 5'd2, 16'h0001);
      #1;
      checks++;
      if (PCBranchD !== 32'h0) begin
         errors++; $display("[TB] FAIL branch_wrap: got %h expected 00000000", PCBranchD);
      end
      PCPlus4D = 32'h0;
      InstrD = itype(6'h04, 5'd1, 5'd2, 16'hFFFF);
      #1;
      checks++;
      if (PCBranchD !== 32'hFFFF_FFFC) begin
         errors++; $display("[TB] FAIL branch_wrap_neg: got %h expected fffffffc", PCBranchD);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         InstrD = randInstr();
         PCPlus4D = $urandom;
         RegWriteW = 1'($urandom); WriteRegW = 5'($urandom_range(0, 4)); ResultW = $urandom;
         RegWriteE = 1'($urandom); MemtoRegE = ($urandom_range(0, 3) == 0);
         WriteRegE = 5'($urandom_range(0, 4)); RtE = 5'($urandom_range(0, 4));
         RegWriteM = 1'($urandom); MemtoRegM = ($urandom_range(0, 3) == 0);
         WriteRegM = 5'($urandom_range(0, 4));
         ALUOutM = ($urandom_range(0, 1) == 0) ? expRead(InstrD[20:16]) : $urandom;
         #1;
         checks++;
         if (RD1_D !== expRead(InstrD[25:21]) || RD2_D !== expRead(InstrD[20:16])) begin
            errors++; $display("[TB] FAIL random_read: got %h/%h expected %h/%h",
               RD1_D, RD2_D, expRead(InstrD[25:21]), expRead(InstrD[20:16]));
         end
         checks++;
         if ({RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD} !== expCtrl(InstrD)) begin
            errors++; $display("[TB] FAIL random_ctrl: instr %h got %b expected %b", InstrD,
               {RegWriteD, RegDstD, ALUsrcD, MemWriteD, MemtoRegD, ALUControlD}, expCtrl(InstrD));
         end
         checks++;
         if ({PCSrcD, StallF, StallD, FlushE} !== {expPcSrc(), {3{expStall()}}} ||
             PCBranchD !== expTarget()) begin
            errors++; $display("[TB] FAIL random_branch: instr %h got %b/%h expected %b/%h", InstrD,
               {PCSrcD, StallF, StallD, FlushE}, PCBranchD, {expPcSrc(), {3{expStall()}}}, expTarget());
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_decode();
      test_load_use();
      test_branch();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode stage sitting directly upstream of the ID/EX pipeline register; produces every D-suffixed signal that register captures.
- Contains the 32x32 register file (written from WB), the main decoder and ALU decoder, the sign extender, branch resolution for beq in ID, and load-use/branch hazard detection.
- Drives StallF/StallD toward the IF side and FlushE into the ID/EX clear input.

Parameters:
- NREG, 32, number of architectural registers (register 0 hard-wired to zero).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  stage clock, rising edge active
- rst_n  in  1  asynchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- PCPlus4D  in  32  PC+4 from IF/ID
- RegWriteW  in  1  WB register write enable
- WriteRegW  in  5  WB destination register
- ResultW  in  32  WB write data
- RegWriteE, MemtoRegE  in  1 each  control bits of the instruction currently in EX
- WriteRegE  in  5  destination register of the EX instruction
- RtE  in  5  rt field of the EX instruction
- RegWriteM, MemtoRegM  in  1 each  control bits of the MEM instruction
- WriteRegM  in  5  destination register of the MEM instruction
- ALUOutM  in  32  ALU result in MEM (branch-compare forwarding source)
- RegWriteD, MemtoRegD, MemWriteD, ALUsrcD, RegDstD  out  1 each  decoded control bits
- ALUControlD  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- RD1_D, RD2_D  out  32  register read data for rs and rt
- RsD, RtD, RdD  out  5  instruction fields [25:21], [20:16], [15:11]
- ext_imm32D  out  32  sign-extended InstrD[15:0]
- PCSrcD  out  1  branch taken
- PCBranchD  out  32  PCPlus4D + (ext_imm32D << 2)
- StallF, StallD  out  1 each  hold PC and IF/ID
- FlushE  out  1  clear ID/EX on the next edge

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers to 0; registers stay 0 while rst_n is low. Outputs are combinational, so during reset RD1_D/RD2_D read 0 and every other output follows the decode of its current inputs.
- Register write: on rising clk, if RegWriteW=1 and WriteRegW!=0, reg[WriteRegW] <= ResultW. Writes to register 0 are ignored.
- Register read: combinational. Register 0 always reads 0.
- Write-before-read bypass: if RegWriteW=1, WriteRegW!=0 and WriteRegW equals the read address, the read returns ResultW in the same cycle.
- Decode (opcode InstrD[31:26], funct InstrD[5:0]). Control vectors are listed as RegWrite, RegDst, ALUsrc, MemWrite, MemtoReg:
  - R-type 000000: 1,1,0,0,0. funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR; any other funct decodes as ADD.
  - lw 100011: 1,0,1,0,1; ADD.
  - sw 101011: 0,x->0,1,1,0; ADD.
  - addi 001000: 1,0,1,0,0; ADD.
  - beq 000100: all control bits 0; SUB.
  - Any other opcode: all control bits 0, ALUControlD=00 (NOP).
- Branch compare operands:
  - Operand A = ALUOutM if RegWriteM=1, WriteRegM!=0 and WriteRegM==RsD; otherwise RD1_D.
  - Operand B uses the same rule with RtD.
  - BranchD=1 for beq. PCSrcD = BranchD & (A==B) & ~StallD.
- Load-use stall: MemtoRegE=1 and (RtE==RsD or RtE==RtD).
- Branch stall, asserted when BranchD=1 and either:
  - RegWriteE=1 and WriteRegE is nonzero and equals RsD or RtD; or
  - MemtoRegM=1 and WriteRegM is nonzero and equals RsD or RtD.
- StallF = StallD = FlushE = load-use stall OR branch stall.
- A stall lasts exactly as long as its condition holds. A load-use stall lasts one cycle. A branch stall lasts up to two cycles.
- Simultaneous WB write and ID read of the same register: the bypass value is used. Stall evaluation is unaffected.
- PCBranchD arithmetic is modulo 2^32; wrap-around is silent.

Test Plan:
- Reset then read: pulse rst_n low mid-run after writing reg5=0x1234 -> RD1_D reads 0 for RsD=5 immediately, without waiting for a clock edge.
- WB bypass: RegWriteW=1, WriteRegW=8, ResultW=0xDEADBEEF, InstrD=add $t0... with rs=8 -> RD1_D=0xDEADBEEF in the same cycle; the next cycle holds the value from storage. Writing reg0=0xFFFF -> reg0 still reads 0.
- Decode sweep: lw $2,-4($3) -> RegWriteD=1, MemtoRegD=1, ALUsrcD=1, RegDstD=0, ext_imm32D=0xFFFFFFFC. sub -> ALUControlD=01, RegDstD=1. Opcode 0x3F -> all control bits 0.
- Load-use: MemtoRegE=1, RtE=4, InstrD has rs=4 -> StallF=StallD=FlushE=1 for one cycle. With RtE=0 and MemtoRegE=0 -> all three 0.
- Branch with MEM forward: beq rs=9, rt=0, RD1_D=7, RegWriteM=1, WriteRegM=9, ALUOutM=0 -> PCSrcD=1, PCBranchD=PCPlus4D+4*imm. With MemtoRegM=1 -> stall=1 and PCSrcD=0.
- Branch wrap: PCPlus4D=0xFFFFFFFC, imm=1 -> PCBranchD=0x00000000.
